// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 5-stage RV32I pipeline: tracks in-flight destination registers
// in shadow EX/MEM/WB slots and derives operand forwarding, load-use stall and redirect flush.
module hazard_ctrl #(
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Only the EX slot's load flag ever matters (load data is forwardable from MEM onward),
    // so MEM/WB keep just valid/rd/we.
    logic             ex_valid_q, ex_valid_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_we_q, ex_we_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_valid_q, mem_valid_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             mem_we_q, mem_we_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    logic hazard, stall;

    function automatic logic slot_match(input logic v, input logic we, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic used, input logic idv);
        return v & we & (rd != 5'd0) & (rd == rs) & used & idv;
    endfunction

    always_comb begin
        a_ex  = slot_match(ex_valid_q,  ex_we_q,  ex_rd_q,  id_rs1, id_rs1_used, id_valid);
        a_mem = slot_match(mem_valid_q, mem_we_q, mem_rd_q, id_rs1, id_rs1_used, id_valid);
        a_wb  = slot_match(wb_valid_q,  wb_we_q,  wb_rd_q,  id_rs1, id_rs1_used, id_valid);
        b_ex  = slot_match(ex_valid_q,  ex_we_q,  ex_rd_q,  id_rs2, id_rs2_used, id_valid);
        b_mem = slot_match(mem_valid_q, mem_we_q, mem_rd_q, id_rs2, id_rs2_used, id_valid);
        b_wb  = slot_match(wb_valid_q,  wb_we_q,  wb_rd_q,  id_rs2, id_rs2_used, id_valid);

        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (FWD_EN != 0) begin
            hazard = ex_load_q & (a_ex | b_ex);
            if (!hazard) begin
                fwd_a_sel = a_ex ? 2'd1 : a_mem ? 2'd2 : a_wb ? 2'd3 : 2'd0;
                fwd_b_sel = b_ex ? 2'd1 : b_mem ? 2'd2 : b_wb ? 2'd3 : 2'd0;
            end
        end else begin
            hazard = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
        end

        // A redirect makes ID wrong-path, so it cancels any stall it would have caused.
        stall       = hazard & ~ex_redirect;
        stall_pc    = stall;
        stall_if_id = stall;
        flush_if_id = ex_redirect;
        flush_id_ex = stall | ex_redirect;
    end

    always_comb begin
        ex_valid_d  = 1'b0;
        ex_rd_d     = 5'd0;
        ex_we_d     = 1'b0;
        ex_load_d   = 1'b0;
        if (id_valid && !stall && !ex_redirect) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = id_rd;
            ex_we_d    = id_rf_we;
            ex_load_d  = id_is_load;
        end
        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_we_d    = ex_we_q;
        wb_valid_d  = mem_valid_q;
        wb_rd_d     = mem_rd_q;
        wb_we_d     = mem_we_q;

        stall_cnt_d = stall_cnt_q;
        if (stall_pc && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush_if_id && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_we_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_we_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
